bram_dwc_down: RTL and testbench

BRAM_DWC_DOWN -- requirements
Module: bram_dwc_down

---
 rtl/bram_dwc_down.sv | 147 ++++++++++++++
 tb/tb_bram_dwc_down.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dwc_down.sv
// Width down-converter: splits one wide master access into N sequential narrow BRAM beats,
// reassembling read data and returning it as a single-cycle pulse.
module bram_dwc_down #(
    parameter int unsigned ADDR_BITW     = 32,
    parameter int unsigned MST_DATA_BITW = 96,
    parameter int unsigned SLV_DATA_BITW = 32
) (
    input  logic                       Clk_C,
    input  logic                       Rst_R,
    input  logic                       MstReq_S,
    output logic                       MstGnt_S,
    input  logic [ADDR_BITW-1:0]       MstAddr_S,
    input  logic [MST_DATA_BITW/8-1:0] MstWrEn_S,
    input  logic [MST_DATA_BITW-1:0]   MstWr_D,
    output logic                       MstRdValid_S,
    output logic [MST_DATA_BITW-1:0]   MstRd_D,
    output logic                       SlvEn_S,
    output logic [ADDR_BITW-1:0]       SlvAddr_S,
    output logic [SLV_DATA_BITW/8-1:0] SlvWrEn_S,
    output logic [SLV_DATA_BITW-1:0]   SlvWr_D,
    input  logic [SLV_DATA_BITW-1:0]   SlvRd_D
);

    localparam int unsigned N         = MST_DATA_BITW / SLV_DATA_BITW;
    localparam int unsigned MST_BYTES = MST_DATA_BITW / 8;
    localparam int unsigned SLV_BYTES = SLV_DATA_BITW / 8;
    localparam int unsigned MST_OFFS  = $clog2(MST_BYTES);
    localparam int unsigned SLV_OFFS  = $clog2(SLV_BYTES);
    localparam int unsigned CNT_W     = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(N - 1);
    localparam logic [ADDR_BITW-1:0] N_A       = ADDR_BITW'(N);

    if ((MST_DATA_BITW % SLV_DATA_BITW) != 0 || N < 2) begin : g_bad_ratio
        $fatal(1, "bram_dwc_down: MST_DATA_BITW must be an integer multiple >= 2 of SLV_DATA_BITW");
    end
    if (SLV_DATA_BITW < 8 || (SLV_DATA_BITW & (SLV_DATA_BITW - 1)) != 0) begin : g_bad_slv
        $fatal(1, "bram_dwc_down: SLV_DATA_BITW must be a power of two >= 8");
    end
    if ((MST_DATA_BITW % 8) != 0) begin : g_bad_mst
        $fatal(1, "bram_dwc_down: MST_DATA_BITW must be a multiple of 8");
    end

    typedef enum logic [1:0] {StIdle, StBeat, StDrain} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           beat_q, beat_d;
    logic [ADDR_BITW-1:0]       word_q, word_d;
    logic [MST_BYTES-1:0]       strb_q, strb_d;
    logic [MST_DATA_BITW-1:0]   wdata_q, wdata_d;
    logic                       is_rd_q, is_rd_d;
    logic [MST_DATA_BITW-1:0]   rd_buf_q, rd_buf_d;
    logic [MST_DATA_BITW-1:0]   mst_rd_q, mst_rd_d;
    logic                       rd_valid_q, rd_valid_d;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        word_d     = word_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        is_rd_d    = is_rd_q;
        rd_buf_d   = rd_buf_q;
        mst_rd_d   = mst_rd_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (MstReq_S) begin
                    word_d  = MstAddr_S >> MST_OFFS;
                    strb_d  = MstWrEn_S;
                    wdata_d = MstWr_D;
                    is_rd_d = ~|MstWrEn_S;
                    beat_d  = '0;
                    state_d = StBeat;
                end
            end
            StBeat: begin
                // Read data lags its beat by one cycle, so capture the previous slice.
                if (is_rd_q && beat_q != '0) begin
                    rd_buf_d[(32'(beat_q) - 32'd1) * SLV_DATA_BITW +: SLV_DATA_BITW] = SlvRd_D;
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = is_rd_q ? StDrain : StIdle;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            StDrain: begin
                rd_buf_d[(N - 1) * SLV_DATA_BITW +: SLV_DATA_BITW] = SlvRd_D;
                mst_rd_d   = rd_buf_d;
                rd_valid_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_C) begin
        if (Rst_R) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            word_q     <= '0;
            strb_q     <= '0;
            wdata_q    <= '0;
            is_rd_q    <= 1'b0;
            rd_buf_q   <= '0;
            mst_rd_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            is_rd_q    <= is_rd_d;
            rd_buf_q   <= rd_buf_d;
            mst_rd_q   <= mst_rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    logic in_beat;
    logic wr_beat;

    always_comb begin
        in_beat      = (state_q == StBeat);
        wr_beat      = in_beat && !is_rd_q;
        MstGnt_S     = (state_q == StIdle);
        MstRdValid_S = rd_valid_q;
        MstRd_D      = mst_rd_q;
        SlvEn_S      = in_beat;
        SlvAddr_S    = '0;
        SlvWrEn_S    = '0;
        SlvWr_D      = '0;
        if (in_beat) begin
            // Arithmetic stays in ADDR_BITW bits, so high address bits wrap naturally.
            SlvAddr_S = (word_q * N_A + ADDR_BITW'(beat_q)) << SLV_OFFS;
        end
        if (wr_beat) begin
            SlvWrEn_S = strb_q[32'(beat_q) * SLV_BYTES +: SLV_BYTES];
            SlvWr_D   = wdata_q[32'(beat_q) * SLV_DATA_BITW +: SLV_DATA_BITW];
        end
    end

endmodule

// File: tb/tb_bram_dwc_down.sv
// Randomised scoreboard bench for bram_dwc_down (N=3, 96-bit master, 32-bit slave BRAM).
module tb_bram_dwc_down;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        Rst_R;
    logic        MstReq_S;
    logic        MstGnt_S;
    logic [31:0] MstAddr_S;
    logic [11:0] MstWrEn_S;
    logic [95:0] MstWr_D;
    logic        MstRdValid_S;
    logic [95:0] MstRd_D;
    logic        SlvEn_S;
    logic [31:0] SlvAddr_S;
    logic [3:0]  SlvWrEn_S;
    logic [31:0] SlvWr_D;
    logic [31:0] SlvRd_D = '0;

    bram_dwc_down #(
        .ADDR_BITW(32),
        .MST_DATA_BITW(96),
        .SLV_DATA_BITW(32)
    ) dut (
        .Clk_C(clk),
        .Rst_R(Rst_R),
        .MstReq_S(MstReq_S),
        .MstGnt_S(MstGnt_S),
        .MstAddr_S(MstAddr_S),
        .MstWrEn_S(MstWrEn_S),
        .MstWr_D(MstWr_D),
        .MstRdValid_S(MstRdValid_S),
        .MstRd_D(MstRd_D),
        .SlvEn_S(SlvEn_S),
        .SlvAddr_S(SlvAddr_S),
        .SlvWrEn_S(SlvWrEn_S),
        .SlvWr_D(SlvWr_D),
        .SlvRd_D(SlvRd_D)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
        logic [3:0]  wren;
        logic [31:0] wdata;
        bit          is_wr;
    } beat_t;

    typedef struct {
        int unsigned cyc;
        logic [95:0] data;
    } rd_t;

    beat_t bq[$];
    rd_t   rq[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          sb_en    = 0;
    int unsigned gnt_ret  = 0;
    int unsigned last_acc = 0;
    logic [95:0] last_rd  = '0;

    logic [31:0] smem[logic [31:0]];
    logic [31:0] rmem[logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_1234;
    endfunction

    function automatic logic [31:0] sget(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Slave BRAM: one-cycle read latency, byte-masked writes.
    initial begin
        logic [31:0] w;
        forever begin
            @(posedge clk);
            if (SlvEn_S) begin
                w = sget(SlvAddr_S);
                if (SlvWrEn_S != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (SlvWrEn_S[b]) w[8*b +: 8] = SlvWr_D[8*b +: 8];
                    smem[SlvAddr_S] = w;
                end
                SlvRd_D <= sget(SlvAddr_S);
            end
        end
    end

    // Monitor: compares every cycle against the expectation queues.
    initial begin
        beat_t b;
        rd_t   r;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                chk("gnt", MstGnt_S, (cyc >= gnt_ret));
                if (SlvEn_S) begin
                    if (bq.size() == 0) chk("slv_en_unexpected", SlvEn_S, 1'b0);
                    else begin
                        b = bq.pop_front();
                        chk("beat_cycle", cyc, b.cyc);
                        chk("beat_addr", SlvAddr_S, b.addr);
                        chk("beat_wren", SlvWrEn_S, b.wren);
                        if (b.is_wr) chk("beat_wdata", SlvWr_D, b.wdata);
                    end
                end else begin
                    chk("idle_slv_outputs", {SlvAddr_S, SlvWrEn_S, SlvWr_D}, '0);
                    if (bq.size() > 0 && bq[0].cyc <= cyc) begin
                        chk("beat_missing_en", SlvEn_S, 1'b1);
                        void'(bq.pop_front());
                    end
                end
                if (MstRdValid_S) begin
                    if (rq.size() == 0) chk("rdvalid_unexpected", MstRdValid_S, 1'b0);
                    else begin
                        r = rq.pop_front();
                        chk("rd_cycle", cyc, r.cyc);
                        chk("rd_data", MstRd_D, r.data);
                        last_rd = r.data;
                    end
                end else begin
                    chk("rd_hold", MstRd_D, last_rd);
                    if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                        chk("rdvalid_missing", MstRdValid_S, 1'b1);
                        void'(rq.pop_front());
                    end
                end
            end
        end
    end

    // Present a request (called #1 after a posedge); returns #1 after its acceptance edge.
    task automatic issue(input logic [31:0] addr, input logic [11:0] strb,
                         input logic [95:0] data, input bit hold);
        int unsigned acc;
        logic [31:0] w;
        logic [31:0] ba;
        logic [31:0] word;
        logic [95:0] exp_rd;
        beat_t       bt;
        rd_t         rt;
        bit          got;
        MstReq_S  = 1'b1;
        MstAddr_S = addr;
        MstWrEn_S = strb;
        MstWr_D   = data;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (MstGnt_S) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", MstGnt_S, 1'b1);
            MstReq_S = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        last_acc = acc;
        gnt_ret  = acc + N + ((strb == 12'h0) ? 1 : 0);
        w        = addr >> 4;
        exp_rd   = '0;
        for (int i = 0; i < N; i++) begin
            ba       = 32'((w * 32'd3 + 32'(i)) << 2);
            bt.cyc   = acc + 32'(i);
            bt.addr  = ba;
            bt.wren  = strb[4*i +: 4];
            bt.wdata = data[32*i +: 32];
            bt.is_wr = (strb != 12'h0);
            bq.push_back(bt);
            if (strb != 12'h0) begin
                word = rget(ba);
                for (int bb = 0; bb < 4; bb++)
                    if (strb[4*i + bb]) word[8*bb +: 8] = data[32*i + 8*bb +: 8];
                rmem[ba] = word;
            end else begin
                exp_rd[32*i +: 32] = rget(ba);
            end
        end
        if (strb == 12'h0) begin
            rt.cyc  = acc + N + 1;
            rt.data = exp_rd;
            rq.push_back(rt);
        end
        if (!hold) MstReq_S = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && (bq.size() > 0 || rq.size() > 0 || !MstGnt_S); k++)
            @(negedge clk);
        if (bq.size() > 0 || rq.size() > 0) chk("drain_timeout", bq.size() + rq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned a1;
        int unsigned gap;
        bit          hold;
        logic [11:0] strb;
        logic [31:0] addr;

        Rst_R     = 1'b1;
        MstReq_S  = 1'b1;
        MstAddr_S = 32'h20;
        MstWrEn_S = 12'hFFF;
        MstWr_D   = {$urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", MstGnt_S, 1'b1);
        chk("reset_rdvalid", MstRdValid_S, 1'b0);
        chk("reset_rd_data", MstRd_D, '0);
        chk("reset_slv_en", SlvEn_S, 1'b0);
        @(posedge clk);
        #1;
        Rst_R    = 1'b0;
        MstReq_S = 1'b0;
        @(negedge clk);
        chk("reset_req_not_accepted", SlvEn_S, 1'b0);
        chk("post_reset_gnt", MstGnt_S, 1'b1);
        #1;
        sb_en = 1;
        @(posedge clk);
        #1;

        smem[32'h18] = 32'h11; rmem[32'h18] = 32'h11;
        smem[32'h1C] = 32'h22; rmem[32'h1C] = 32'h22;
        smem[32'h20] = 32'h33; rmem[32'h20] = 32'h33;
        issue(32'h20, 12'h000, '0, 0);
        wait_idle();

        issue(32'h20, 12'hFFF, 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA, 0);
        wait_idle();
        issue(32'h30, 12'h0F0, {$urandom, $urandom, $urandom}, 0);
        wait_idle();
        issue(32'h30, 12'h000, '0, 0);
        wait_idle();
        issue(32'h20, 12'h000, '0, 0);
        wait_idle();

        issue(32'h30, 12'h000, '0, 1);
        a1 = last_acc;
        issue(32'h20, 12'h000, '0, 0);
        chk("b2b_accept_gap", last_acc - a1, N + 2);
        wait_idle();

        issue(32'h40, 12'h000, '0, 0);
        @(posedge clk);
        #1;
        sb_en = 0;
        Rst_R = 1'b1;
        @(posedge clk);
        #1;
        Rst_R = 1'b0;
        @(negedge clk);
        chk("midreset_slv_en", SlvEn_S, 1'b0);
        chk("midreset_gnt", MstGnt_S, 1'b1);
        chk("midreset_rd_data", MstRd_D, '0);
        for (int k = 0; k < 6; k++) begin
            chk("midreset_no_rdvalid", MstRdValid_S, 1'b0);
            @(negedge clk);
        end
        #1;
        bq.delete();
        rq.delete();
        gnt_ret = 0;
        last_rd = '0;
        sb_en   = 1;
        @(posedge clk);
        #1;

        issue(32'hFFFF_FFF0, 12'hA5C, {$urandom, $urandom, $urandom}, 0);
        issue(32'hFFFF_FFF0, 12'h000, '0, 0);
        wait_idle();

        for (int t = 0; t < 80; t++) begin
            strb = ($urandom_range(0, 9) < 4) ? 12'h000 : 12'($urandom_range(1, 4095));
            if ($urandom_range(0, 3) == 0) addr = (32'h0FFF_FFF0 + $urandom_range(0, 15)) << 4;
            else addr = 32'($urandom_range(0, 7)) << 4;
            addr = addr | 32'($urandom_range(0, 15));
            hold = ($urandom_range(0, 2) == 0);
            issue(addr, strb, {$urandom, $urandom, $urandom}, hold);
            gap = hold ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
